// File: rtl/arbitro_memoria_dados_pkg.sv
// Shared constants and types for the data-memory arbiter.
// Port indices, bus widths and the latched access record live here.
package arb_mem_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_AUX = 1'b1
   } port_e;

   typedef struct packed {
      port_e             port;
      logic              rd;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] din;
   } acc_t;

   // The picker output is one-hot, so bit 1 alone identifies the auxiliary port.
   function automatic port_e portOf(input logic [1:0] gnt);
      return gnt[1] ? PORT_AUX : PORT_CPU;
   endfunction

endpackage

// File: rtl/arbitro_memoria_dados_if.sv
// Requester and memory-side bundle for arbitro_memoria_dados.
// The slave modport is the arbiter's view; master is the environment's view.
interface arbitro_memoria_dados_if;
   import arb_mem_pkg::*;

   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              rvalid0;
   logic              rvalid1;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_memR;
   logic              mem_memW;
   logic [DATA_W-1:0] mem_DIN;
   logic [DATA_W-1:0] mem_DOUT;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_DOUT,
      output gnt0, gnt1, rvalid0, rvalid1, rdata,
             mem_addr, mem_memR, mem_memW, mem_DIN
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_DOUT,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata,
             mem_addr, mem_memR, mem_memW, mem_DIN
   );

endinterface

// File: rtl/arbitro_memoria_dados_rr_pick2.sv
// Two-requester picker producing a one-hot grant.
// ARB_RR_EN selects round-robin via prefer_i; otherwise port 0 has fixed priority.
module rr_pick2
   import arb_mem_pkg::*;
(
   input  logic [1:0] req_i,
`ifdef ARB_RR_EN
   input  logic       prefer_i,
`endif
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      if (req_i == 2'b11) begin
`ifdef ARB_RR_EN
         gnt_o[prefer_i] = 1'b1;
`else
         gnt_o[PORT_CPU] = 1'b1;
`endif
      end else begin
         gnt_o = req_i;
      end
   end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Arbiter and ARB/ACC/RSP access sequencer for the 256x8 data memory.
// Define ARB_RR_EN for round-robin arbitration; the default is fixed priority to port 0.
module arbitro_memoria_dados
   import arb_mem_pkg::*;
(
   input logic                    clk,
   input logic                    rst_n,
   arbitro_memoria_dados_if.slave bus
);

   logic [1:0]        reqVec;
   logic [1:0]        gntVec;
   logic              xfer;
   port_e             winner;
   logic              selWe;
   logic [ADDR_W-1:0] selAddr;
   logic [DATA_W-1:0] selData;

   acc_t              acc_q,    acc_d;
   logic [DATA_W-1:0] rdata_q,  rdata_d;
   logic [1:0]        rvalid_q, rvalid_d;

`ifdef ARB_RR_EN
   logic              preferAux_q, preferAux_d;
`endif

   // Masking requests with rst_n keeps both grants low throughout reset.
   assign reqVec = {bus.req1, bus.req0} & {2{rst_n}};

   rr_pick2 u_pick (
      .req_i    (reqVec),
`ifdef ARB_RR_EN
      .prefer_i (preferAux_q),
`endif
      .gnt_o    (gntVec)
   );

   assign bus.gnt0 = gntVec[PORT_CPU];
   assign bus.gnt1 = gntVec[PORT_AUX];

   always_comb begin
      xfer    = |gntVec;
      winner  = portOf(gntVec);
      selWe   = bus.we0;
      selAddr = bus.addr0;
      selData = bus.wdata0;
      if (winner == PORT_AUX) begin
         selWe   = bus.we1;
         selAddr = bus.addr1;
         selData = bus.wdata1;
      end
   end

   // Address and DIN hold between accesses; only the strobes fall back to 0.
   always_comb begin
      acc_d      = acc_q;
      acc_d.rd   = 1'b0;
      acc_d.wr   = 1'b0;
      if (xfer) begin
         acc_d.port = winner;
         acc_d.addr = selAddr;
         acc_d.rd   = ~selWe;
         acc_d.wr   = selWe;
         if (selWe) begin
            acc_d.din = selData;
         end
      end
   end

   always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = 2'b00;
      if (acc_q.rd) begin
         rdata_d             = bus.mem_DOUT;
         rvalid_d[acc_q.port] = 1'b1;
      end
   end

`ifdef ARB_RR_EN
   // After serving a port, the other one wins the next conflict.
   always_comb begin
      preferAux_d = preferAux_q;
      if (xfer) begin
         preferAux_d = (winner == PORT_CPU);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 2'b00;
`ifdef ARB_RR_EN
         preferAux_q <= 1'b0;
`endif
      end else begin
         acc_q    <= acc_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
`ifdef ARB_RR_EN
         preferAux_q <= preferAux_d;
`endif
      end
   end

   assign bus.mem_addr = acc_q.addr;
   assign bus.mem_memR = acc_q.rd;
   assign bus.mem_memW = acc_q.wr;
   assign bus.mem_DIN  = acc_q.din;
   assign bus.rdata    = rdata_q;
   assign bus.rvalid0  = rvalid_q[PORT_CPU];
   assign bus.rvalid1  = rvalid_q[PORT_AUX];

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Scoreboard bench for arbitro_memoria_dados with a behavioural 256x8 data memory.
// Memory image: location i holds 8'h30 + i.
module tb_arbitro_memoria_dados;
   import arb_mem_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   arbitro_memoria_dados_if busIf ();

   arbitro_memoria_dados dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busIf)
   );

   logic [DATA_W-1:0] mem [256];
   logic              memReady = 1'b0;

   // The memory commits writes on the falling edge and reads asynchronously.
   always @(negedge clk) begin
      if (!memReady) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(8'h30 + i);
         memReady <= 1'b1;
      end else if (busIf.mem_memW) begin
         mem[busIf.mem_addr] <= busIf.mem_DIN;
      end
   end

   assign busIf.mem_DOUT = busIf.mem_memR ? mem[busIf.mem_addr] : 8'h00;

   typedef struct packed {
      logic       rstn;
      logic       r0;
      logic       w0;
      logic [7:0] a0;
      logic [7:0] d0;
      logic       r1;
      logic       w1;
      logic [7:0] a1;
      logic [7:0] d1;
      logic       g0;
      logic       g1;
      logic       rsp;
      logic [7:0] expData;
   } vec_t;

   typedef struct packed {
      logic        port;
      logic [7:0]  data;
      logic [31:0] due;
   } exp_t;

   exp_t       scoreboard [$];
   vec_t       vecs [$];
   int         checkCount = 0;
   int         passCount  = 0;
   int         cyc        = 0;
   logic [7:0] lastExp    = 8'h00;
   logic       sawReset   = 1'b0;
   logic       expR = 1'b0, expW = 1'b0, prevRst = 1'b0;
   logic [7:0] expA = 8'h00, expD = 8'h00;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checkCount++;
      if (act === req) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endtask

   function automatic vec_t mk(input logic rstn, r0, w0, input logic [7:0] a0, d0,
                               input logic r1, w1, input logic [7:0] a1, d1,
                               input logic g0, g1, rsp, input logic [7:0] expData);
      vec_t v;
      v.rstn = rstn; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.g0 = g0; v.g1 = g1; v.rsp = rsp; v.expData = expData;
      return v;
   endfunction

   // Pops an expectation whenever rvalid shows; checks rdata holds otherwise.
   task automatic monitorLoop();
      exp_t       e;
      logic [1:0] rv;
      forever begin
         @(posedge clk);
         sawReset = !rst_n;
         cyc++;
         @(negedge clk);
         rv = {busIf.rvalid1, busIf.rvalid0};
         if (rv != 2'b00) begin
            if (scoreboard.size() == 0) begin
               checkOutput("rvalid_unexpected", 32'(rv), 32'(0));
            end else begin
               e = scoreboard.pop_front();
               checkOutput("rvalid_port", 32'(rv), 32'(e.port ? 2'b10 : 2'b01));
               checkOutput("rdata", 32'(busIf.rdata), 32'(e.data));
               checkOutput("latency", 32'(cyc), e.due);
               lastExp = e.data;
            end
         end else begin
            if (sawReset) lastExp = 8'h00;
            checkOutput("rdata_hold", 32'(busIf.rdata), 32'(lastExp));
            if (scoreboard.size() > 0 && scoreboard[0].due <= 32'(cyc)) begin
               e = scoreboard.pop_front();
               checkOutput("rvalid_at_due", 32'(rv), 32'(e.port ? 2'b10 : 2'b01));
            end
         end
      end
   endtask

   // One cycle: drive, check ACC strobes and grants, then queue the read response.
   task automatic applyStimulus(input vec_t v);
      rst_n        = v.rstn;
      busIf.req0   = v.r0;
      busIf.we0    = v.w0;
      busIf.addr0  = v.a0;
      busIf.wdata0 = v.d0;
      busIf.req1   = v.r1;
      busIf.we1    = v.w1;
      busIf.addr1  = v.a1;
      busIf.wdata1 = v.d1;
      @(negedge clk);
      checkOutput("acc_memR", 32'(busIf.mem_memR), 32'(expR));
      checkOutput("acc_memW", 32'(busIf.mem_memW), 32'(expW));
      if (expR || expW) checkOutput("acc_addr", 32'(busIf.mem_addr), 32'(expA));
      if (expW) checkOutput("acc_din", 32'(busIf.mem_DIN), 32'(expD));
      if (prevRst) begin
         checkOutput("rst_addr", 32'(busIf.mem_addr), 32'(0));
         checkOutput("rst_din", 32'(busIf.mem_DIN), 32'(0));
      end
      checkOutput("gnt", 32'({busIf.gnt1, busIf.gnt0}), 32'({v.g1, v.g0}));
      expR = 1'b0;
      expW = 1'b0;
      if (v.g0) begin
         expR = !v.w0; expW = v.w0; expA = v.a0; expD = v.d0;
         if (!v.w0 && v.rsp) scoreboard.push_back('{port: 1'b0, data: v.expData, due: 32'(cyc + 2)});
      end else if (v.g1) begin
         expR = !v.w1; expW = v.w1; expA = v.a1; expD = v.d1;
         if (!v.w1 && v.rsp) scoreboard.push_back('{port: 1'b1, data: v.expData, due: 32'(cyc + 2)});
      end
      prevRst = !v.rstn;
      @(posedge clk);
      #1;
   endtask

   initial begin
      fork
         monitorLoop();
      join_none

      // Reset held with req0 up: no grant, everything at zero.
      repeat (2) vecs.push_back(mk(0, 1,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00));

      // Conflict: port 0 reads 0x01, port 1 reads 0x02, both held for 4 cycles.
`ifdef ARB_RR_EN
      vecs.push_back(mk(1, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00, 1,0,1,8'h31));
      vecs.push_back(mk(1, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00, 0,1,1,8'h32));
      vecs.push_back(mk(1, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00, 1,0,1,8'h31));
      vecs.push_back(mk(1, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00, 0,1,1,8'h32));
`else
      repeat (4) vecs.push_back(mk(1, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00, 1,0,1,8'h31));
`endif

      // Write 0xA5 to 0x10, then read it back the next cycle.
      vecs.push_back(mk(1, 1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 1,0,0,8'h00));
      vecs.push_back(mk(1, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 1,0,1,8'hA5));

      // Back-to-back reads of 0x00..0x03 from port 1.
      vecs.push_back(mk(1, 0,0,8'h00,8'h00, 1,0,8'h00,8'h00, 0,1,1,8'h30));
      vecs.push_back(mk(1, 0,0,8'h00,8'h00, 1,0,8'h01,8'h00, 0,1,1,8'h31));
      vecs.push_back(mk(1, 0,0,8'h00,8'h00, 1,0,8'h02,8'h00, 0,1,1,8'h32));
      vecs.push_back(mk(1, 0,0,8'h00,8'h00, 1,0,8'h03,8'h00, 0,1,1,8'h33));

      // Three idle cycles, a lone read, then idle again.
      repeat (3) vecs.push_back(mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00));
      vecs.push_back(mk(1, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 1,0,1,8'hA5));
      repeat (2) vecs.push_back(mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00));

      // Port 1 read of 0x05, reset asserted during its ACC cycle: no response.
      vecs.push_back(mk(1, 0,0,8'h00,8'h00, 1,0,8'h05,8'h00, 0,1,0,8'h00));
      repeat (2) vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00));
      repeat (4) vecs.push_back(mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00));

      foreach (vecs[i]) applyStimulus(vecs[i]);

      checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'(0));
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/arbitro_memoria_dados.md
# arbitro_memoria_dados

Two-port arbiter and access sequencer for the 256×8 data memory. It shares the memory between the CPU load/store port (port 0) and a second requester such as a DMA or debug loader (port 1), and accepts at most one access per cycle. It drives the memory's address, memR, memW and DIN lines from registers and returns registered read data to the owning port. It sits between the two requesters and the data memory.

## Interface
- ADDR_W, 8, address width; must match the data memory.
- DATA_W, 8, data width; must match the data memory.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0 / req1  in  1  port request; held with its qualifiers until granted.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  access address.
- wdata0 / wdata1  in  DATA_W  write data.
- gnt0 / gnt1  out  1  combinational accept; a transfer occurs on a rising edge where reqN & gntN.
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata holds that port's read result.
- rdata  out  DATA_W  registered read data, shared by both ports.
- mem_addr  out  ADDR_W  to memory addr.
- mem_memR  out  1  to memory memR.
- mem_memW  out  1  to memory memW.
- mem_DIN  out  DATA_W  to memory DIN.
- mem_DOUT  in  DATA_W  from memory DOUT (asynchronous read, forced to 0 when memR = 0).

## Operation
- Three stages: ARB (combinational pick), ACC (registered access), RSP (registered response).
- ARB: at most one of gnt0/gnt1 is high, and only if its req is high. Both gnt are 0 while rst_n = 0.
- Arbitration policy: see Configuration.
- Transfer at edge E: the winner's addr, we and wdata are latched into the ACC registers, and acc_valid = 1, acc_port = winner.
- ACC cycle: mem_addr = latched address. Read: mem_memR = 1, mem_memW = 0. Write: mem_memW = 1, mem_memR = 0, mem_DIN = latched data. With no access, both strobes are 0.
- The memory commits a write on the falling edge inside the ACC cycle.
- Read in ACC: at the next rising edge, rdata <= mem_DOUT and rvalid[acc_port] <= 1 for one cycle. A write produces no rvalid.
- The pipeline never stalls. A new transfer may be accepted every cycle, and requesters must accept rvalid unconditionally.
- A read following a write to the same address in the next cycle returns the new data, because the write commits at the falling edge before the read's ACC cycle.
- A requester that keeps req high after a transfer issues a new request for the same access.
- An idle cycle (no req) leaves acc_valid = 0, and both strobes drop in the following cycle.
- rdata holds its last value when no read completes.

## Timing
- Reset values: mem_addr = 0, mem_DIN = 0, mem_memR = 0, mem_memW = 0, rdata = 0, rvalid0/1 = 0, acc_valid = 0, RR pointer = "port 0 preferred".
- Reset mid-operation: any in-flight access and pending rvalid are discarded. Strobes are 0 in the cycle after the reset edge.
- Read latency: transfer edge E, then the access in cycle E+1, then rvalid in cycle E+2 (2 cycles req-accepted to data).
- Write completes at the falling edge of cycle E+1.
- Throughput: 1 access per cycle, summed over both ports.
- Simultaneous req0 & req1: exactly one grant; the loser holds req and is served no earlier than the next cycle.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer records the last served port and updates only on a transfer.
  - On a conflict, the port not served last wins. After reset, port 0 wins the first conflict.
- ARB_RR_EN undefined: fixed priority, port 0 always wins.
  - Port 1 can starve under continuous req0; this is accepted behaviour.
  - No pointer register is present.

## Structure
- Shared package arb_mem_pkg holds the port index constants PORT_CPU = 0 and PORT_AUX = 1, plus the default ADDR_W/DATA_W.
- One sub-module, rr_pick2: the 2-requester picker (req vector + pointer in, one-hot grant out), with its behaviour selected by ARB_RR_EN.
- ACC and RSP registers live in arbitro_memoria_dados.

## Test plan
- Reset: hold rst_n = 0 with req0 = 1 → gnt0 = 0, all outputs 0. Release → gnt0 = 1 on the first cycle.
- Single write then read: port 0 writes 0xA5 to address 0x10, then reads 0x10 in the next cycle.
  - Expected: memW high for 1 cycle, then memR high.
  - Expected: rvalid0 with rdata = 0xA5 two cycles after the read transfer, and rvalid1 stays 0.
- Conflict: req0 and req1 held continuously for 4 cycles.
  - With ARB_RR_EN, grants are 0,1,0,1.
  - Without it, grants are 0,0,0,0 and gnt1 is never asserted.
- Back-to-back reads of 0x00–0x03 from port 1 → four consecutive rvalid1 pulses with rdata matching the memory file contents, and no idle cycles between them.
- Reset mid-read: assert rst_n = 0 during a read's ACC cycle → no rvalid afterwards, and strobes are 0.
- Idle gaps: a single request after 3 idle cycles → strobes are 0 during the idle cycles, and rdata retains its previous value until the new read's rvalid.
